// File: rtl/shared_pin_arbiter_if.sv
// Bundles the per-core request/data lines and the arbitrated shared-line signals.
interface shared_pin_arbiter_if #(parameter int N = 2);
  logic [N-1:0] req;
  logic [N-1:0] dout;
  logic [N-1:0] gnt;
  logic [N-1:0] timeout_err;
  logic         line_oe;
  logic         line_out;
  logic         line_in;
  logic         mirror;
  logic         busy;

  modport master (
    output req, dout, line_in,
    input  gnt, line_oe, line_out, mirror, timeout_err, busy
  );

  modport slave (
    input  req, dout, line_in,
    output gnt, line_oe, line_out, mirror, timeout_err, busy
  );
endinterface

// File: rtl/shared_pin_arbiter.sv
// Round-robin owner arbitration of one shared port line with turnaround gap and hold timeout.
// Define PIN_ARB_SYNC_EN to put 2-flop synchronizers on req and line_in.
module shared_pin_arbiter #(
  parameter int N       = 2,
  parameter int GAP     = 1,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  shared_pin_arbiter_if.slave  bus
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [3:0]       GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE = 2'd0, TURN = 2'd1, OWN = 2'd2} state_t;

  state_t           state_r, state_next_s;
  logic [IDX_W-1:0] owner_r, owner_next_s;
  logic [IDX_W-1:0] ptr_r, ptr_next_s;
  logic [N-1:0]     block_r, block_next_s;
  logic [3:0]       gap_cnt_r, gap_next_s;
  logic [CNT_W-1:0] to_cnt_r, to_next_s;
  logic [N-1:0]     gnt_r, gnt_next_s;
  logic [N-1:0]     terr_r, terr_next_s;
  logic             mirror_r;
  logic [N-1:0]     req_s;
  logic             line_in_s;
  logic [N-1:0]     elig_s;
  logic [IDX_W:0]   pick_s, rel_pick_s;
  logic             start_s, expire_s;
  logic [IDX_W-1:0] start_idx_s;

  // First set bit of elig at or after base, wrapping N-1 -> 0; MSB of result = found.
  function automatic logic [IDX_W:0] rr_pick(input logic [N-1:0] elig, input logic [IDX_W-1:0] base);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] idx_v;
    int               idx;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(base) + k;
      if (idx >= N) idx = idx - N;
      idx_v = IDX_W'(idx);
      if (elig[idx_v]) res = {1'b1, idx_v};
    end
    return res;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(N - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

`ifdef PIN_ARB_SYNC_EN
  logic [N-1:0] req_meta_r, req_sync_r;
  logic         li_meta_r, li_sync_r;

  // Two-stage synchronizers for asynchronous core inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_meta_r <= '0;
      req_sync_r <= '0;
      li_meta_r  <= 1'b0;
      li_sync_r  <= 1'b0;
    end else begin
      req_meta_r <= bus.req;
      req_sync_r <= req_meta_r;
      li_meta_r  <= bus.line_in;
      li_sync_r  <= li_meta_r;
    end
  end

  assign req_s     = req_sync_r;
  assign line_in_s = li_sync_r;
`else
  assign req_s     = bus.req;
  assign line_in_s = bus.line_in;
`endif

  // Next-state, grant and counter logic
  always_comb begin
    state_next_s = state_r;
    owner_next_s = owner_r;
    ptr_next_s   = ptr_r;
    block_next_s = block_r & req_s;
    gap_next_s   = gap_cnt_r;
    to_next_s    = to_cnt_r;
    gnt_next_s   = gnt_r;
    terr_next_s  = '0;
    elig_s       = req_s & ~block_r;
    pick_s       = rr_pick(elig_s, ptr_r);
    rel_pick_s   = '0;
    expire_s     = 1'b0;
    start_s      = 1'b0;
    start_idx_s  = '0;
    case (state_r)
      IDLE: begin
        if (pick_s[IDX_W]) begin
          start_s     = 1'b1;
          start_idx_s = pick_s[IDX_W-1:0];
        end else begin
          state_next_s = IDLE;
        end
      end
      TURN: begin
        if (!req_s[owner_r]) begin
          state_next_s = IDLE;
        end else if (gap_cnt_r == 4'd0) begin
          state_next_s = OWN;
          gnt_next_s   = onehot(owner_r);
          to_next_s    = '0;
        end else begin
          gap_next_s = gap_cnt_r - 4'd1;
        end
      end
      OWN: begin
        expire_s = (TIMEOUT > 0) && (to_cnt_r == TO_LAST);
        if (!req_s[owner_r] || expire_s) begin
          gnt_next_s   = '0;
          state_next_s = IDLE;
          ptr_next_s   = next_idx(owner_r);
          // A drop coinciding with expiry is a clean release, not a fault
          if (req_s[owner_r]) begin
            terr_next_s           = onehot(owner_r);
            block_next_s[owner_r] = 1'b1;
          end else begin
            terr_next_s = '0;
          end
          rel_pick_s = rr_pick(elig_s & ~onehot(owner_r), next_idx(owner_r));
          if (rel_pick_s[IDX_W]) begin
            start_s     = 1'b1;
            start_idx_s = rel_pick_s[IDX_W-1:0];
          end else begin
            start_s = 1'b0;
          end
        end else if (to_cnt_r != '1) begin
          to_next_s = to_cnt_r + CNT_W'(1);
        end else begin
          to_next_s = to_cnt_r;
        end
      end
      default: begin
        state_next_s = IDLE;
        gnt_next_s   = '0;
      end
    endcase
    if (start_s) begin
      owner_next_s = start_idx_s;
      if (GAP == 0) begin
        state_next_s = OWN;
        gnt_next_s   = onehot(start_idx_s);
        to_next_s    = '0;
      end else begin
        state_next_s = TURN;
        gap_next_s   = GAP_LAST;
      end
    end else begin
      owner_next_s = owner_next_s;
    end
  end

  // State, ownership, counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      owner_r   <= '0;
      ptr_r     <= '0;
      block_r   <= '0;
      gap_cnt_r <= 4'd0;
      to_cnt_r  <= '0;
      gnt_r     <= '0;
      terr_r    <= '0;
      mirror_r  <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      owner_r   <= owner_next_s;
      ptr_r     <= ptr_next_s;
      block_r   <= block_next_s;
      gap_cnt_r <= gap_next_s;
      to_cnt_r  <= to_next_s;
      gnt_r     <= gnt_next_s;
      terr_r    <= terr_next_s;
      mirror_r  <= line_in_s;
    end
  end

  assign bus.gnt         = gnt_r;
  assign bus.timeout_err = terr_r;
  assign bus.line_oe     = |gnt_r;
  assign bus.line_out    = (state_r == OWN) ? bus.dout[owner_r] : 1'b1;
  assign bus.mirror      = mirror_r;
  assign bus.busy        = (state_r != IDLE);

endmodule
